shift_normaliser: RTL and testbench

Iterative normaliser: the inverse companion to the barrel shifter. Given a 32-bit value, it finds the shift amount that brings the most significant set bit to bit 31. In trailing mode it finds the amount that brings the least significant set bit to bit 0. It returns that count together with the normalised value. It sits beside the shifter in the ALU path, feeding COUNT into the shifter's SHFT for float/divide prep and bit-scan instructions. It resolves one binary-search stage (16, 8, 4, 2, 1) per clock.

---
 rtl/shift_normaliser_pkg.sv | 28 ++
 rtl/shift_normaliser_bitrev.sv | 14 +
 rtl/shift_normaliser.sv | 174 +++++++++++++++++
 tb/tb_shift_normaliser.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_normaliser_pkg.sv
// Shared types and constants for the iterative leading/trailing-zero normaliser.
package shift_normaliser_pkg;

  localparam int unsigned NORM_STAGES = 5;
  localparam int unsigned NORM_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } shift_norm_state_t;

  // Top-w-bits window tested by binary-search stage s (w = 2^s).
  function automatic logic [NORM_WIDTH-1:0] stage_mask(input logic [2:0] s);
    case (s)
      3'd4:    return 32'hFFFF_0000;
      3'd3:    return 32'hFF00_0000;
      3'd2:    return 32'hF000_0000;
      3'd1:    return 32'hC000_0000;
      default: return 32'h8000_0000;
    endcase
  endfunction

  function automatic logic [4:0] stage_width(input logic [2:0] s);
    return 5'(1 << s);
  endfunction

endpackage

// File: rtl/shift_normaliser_bitrev.sv
// 32-bit combinational bit reversal used around the normaliser core in trailing mode.
module bit_reverse32 (
  input  logic [31:0] a_i,
  output logic [31:0] y_o
);

  always_comb begin
    y_o = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      y_o[i] = a_i[31-i];
    end
  end

endmodule

// File: rtl/shift_normaliser.sv
// Iterative normaliser: one binary-search stage (16,8,4,2,1) per clock, 6-clock latency.
// Optional trailing-zero mode enabled by macro SHIFT_NORMALISER_TRAILING_EN.
module shift_normaliser
  import shift_normaliser_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NORM_WIDTH-1:0] IN,
  input  logic                  START,
  input  logic                  TRAILING,
  output logic [NORM_WIDTH-1:0] OUT,
  output logic [5:0]            COUNT,
  output logic                  ZERO,
  output logic                  BUSY,
  output logic                  DONE
);

  shift_norm_state_t     state_q, state_d;
  logic [2:0]            stage_q, stage_d;
  logic [NORM_WIDTH-1:0] v_q, v_d;
  logic [4:0]            c_q, c_d;
  logic                  zero_lat_q, zero_lat_d;
  logic                  trail_q, trail_d;
  logic [NORM_WIDTH-1:0] out_q, out_d;
  logic [5:0]            count_q, count_d;
  logic                  zero_q, zero_d;
  logic                  done_q, done_d;

  logic [NORM_WIDTH-1:0] in_eff;
  logic [NORM_WIDTH-1:0] v_fin;
  logic                  trail_eff;

`ifdef SHIFT_NORMALISER_TRAILING_EN
  logic [NORM_WIDTH-1:0] in_rev;
  logic [NORM_WIDTH-1:0] v_rev;

  bit_reverse32 u_rev_in (
    .a_i (IN),
    .y_o (in_rev)
  );

  bit_reverse32 u_rev_out (
    .a_i (v_q),
    .y_o (v_rev)
  );

  assign trail_eff = TRAILING;
  assign in_eff    = TRAILING ? in_rev : IN;
  assign v_fin     = trail_q ? v_rev : v_q;
`else
  logic unused_trailing;

  assign unused_trailing = TRAILING;
  assign trail_eff       = 1'b0;
  assign in_eff          = IN;
  assign v_fin           = v_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      v_q        <= '0;
      c_q        <= '0;
      zero_lat_q <= 1'b0;
      trail_q    <= 1'b0;
      out_q      <= '0;
      count_q    <= '0;
      zero_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      v_q        <= v_d;
      c_q        <= c_d;
      zero_lat_q <= zero_lat_d;
      trail_q    <= trail_d;
      out_q      <= out_d;
      count_q    <= count_d;
      zero_q     <= zero_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    v_d        = v_q;
    c_d        = c_q;
    zero_lat_d = zero_lat_q;
    trail_d    = trail_q;
    out_d      = out_q;
    count_d    = count_q;
    zero_d     = zero_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          state_d    = RUN;
          stage_d    = 3'(NORM_STAGES - 1);
          v_d        = in_eff;
          c_d        = '0;
          zero_lat_d = (IN == '0);
          trail_d    = trail_eff;
          out_d      = '0;
          count_d    = '0;
          zero_d     = 1'b0;
        end
      end

      RUN: begin
        if ((v_q & stage_mask(stage_q)) == '0) begin
          v_d = v_q << stage_width(stage_q);
          c_d = c_q + stage_width(stage_q);
        end
        if (stage_q == '0) begin
          state_d = FINISH;
        end else begin
          stage_d = stage_q - 3'd1;
        end
      end

      FINISH: begin
        // A zero operand walks every stage to C=31; report 32 and force OUT to 0.
        state_d = IDLE;
        done_d  = 1'b1;
        zero_d  = zero_lat_q;
        count_d = zero_lat_q ? 6'd32 : {1'b0, c_q};
        out_d   = zero_lat_q ? '0 : v_fin;
      end

      default: state_d = IDLE;
    endcase
  end

  assign OUT   = out_q;
  assign COUNT = count_q;
  assign ZERO  = zero_q;
  assign BUSY  = (state_q != IDLE);
  assign DONE  = done_q;

`ifndef SYNTHESIS
  logic [NORM_WIDTH-1:0] in_shadow_q;
  logic                  trail_shadow_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      in_shadow_q    <= '0;
      trail_shadow_q <= 1'b0;
    end else if (state_q == IDLE && START) begin
      in_shadow_q    <= IN;
      trail_shadow_q <= trail_eff;
    end
  end

  a_start_ignored_when_busy: assert property (
    @(posedge CLK) disable iff (RST) (BUSY && START) |=> $stable(in_shadow_q)
  );

  always_ff @(posedge CLK) begin
    if (!RST && DONE) begin
      if (trail_shadow_q) begin
        assert (OUT == (in_shadow_q >> COUNT));
        assert (ZERO || OUT[0]);
      end else begin
        assert (OUT == (in_shadow_q << COUNT));
        assert (ZERO || OUT[31]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_shift_normaliser.sv
// Self-checking bench for shift_normaliser: directed, randomized and control-path scenarios.
module tb_shift_normaliser;

`ifdef SHIFT_NORMALISER_TRAILING_EN
  localparam bit TR_EN = 1'b1;
`else
  localparam bit TR_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IN = '0;
  logic        START = 1'b0;
  logic        TRAILING = 1'b0;
  logic [31:0] OUT;
  logic [5:0]  COUNT;
  logic        ZERO;
  logic        BUSY;
  logic        DONE;

  int checks = 0;
  int failures = 0;

  shift_normaliser dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN       (IN),
    .START    (START),
    .TRAILING (TRAILING),
    .OUT      (OUT),
    .COUNT    (COUNT),
    .ZERO     (ZERO),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  // Reference: scan for the first set bit from the relevant end and shift it into place.
  task automatic model(input logic [31:0] a, input logic t,
                       output logic [31:0] o, output logic [5:0] c, output logic z);
    int n;
    logic tr;
    tr = t && TR_EN;
    if (a == 32'd0) begin
      o = '0; c = 6'd32; z = 1'b1;
    end else begin
      n = 0;
      if (!tr) begin
        while (a[31-n] == 1'b0) n++;
        o = a << n;
      end else begin
        while (a[n] == 1'b0) n++;
        o = a >> n;
      end
      c = 6'(n);
      z = 1'b0;
    end
  endtask

  // Issue one request, return results and the accept-to-DONE latency (bounded).
  task automatic do_op(input logic [31:0] a, input logic t,
                       output logic [31:0] o, output logic [5:0] c, output logic z,
                       output int lat, output bit busy_ok);
    @(negedge CLK);
    IN = a; TRAILING = t; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    busy_ok = (BUSY === 1'b1) && (DONE === 1'b0);
    lat = 0;
    while (DONE !== 1'b1 && lat < 20) begin
      @(posedge CLK); #1;
      lat++;
      if (lat < 6 && BUSY !== 1'b1) busy_ok = 1'b0;
    end
    o = OUT; c = COUNT; z = ZERO;
  endtask

  task automatic test_reset();
    logic [31:0] o; logic [5:0] c; logic z; int lat; bit bok;
    #1;
    checks++;
    if ({OUT, COUNT, ZERO, BUSY, DONE} !== '0) begin
      failures++;
      $display("FAIL reset_values got OUT=%h COUNT=%0d ZERO=%b BUSY=%b DONE=%b exp all 0",
               OUT, COUNT, ZERO, BUSY, DONE);
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    do_op(32'h0001_0000, 1'b0, o, c, z, lat, bok);
    #1 RST = 1'b1;
    #1;
    checks++;
    if ({OUT, COUNT, ZERO, BUSY, DONE} !== '0) begin
      failures++;
      $display("FAIL async_reset got OUT=%h COUNT=%0d DONE=%b exp 0", OUT, COUNT, DONE);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] vin  [5] = '{32'h0001_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0000_0100};
    logic        vtr  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [5:0]  vcnt [5] = '{6'd15, 6'd32, 6'd0, 6'd31, (TR_EN ? 6'd8 : 6'd23)};
    logic [31:0] vout [5] = '{32'h8000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000,
                              (TR_EN ? 32'h0000_0001 : 32'h8000_0000)};
    logic        vz   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] o; logic [5:0] c; logic z; int lat; bit bok;
    for (int i = 0; i < 5; i++) begin
      do_op(vin[i], vtr[i], o, c, z, lat, bok);
      checks++;
      if (lat != 6 || !bok || BUSY !== 1'b0) begin
        failures++;
        $display("FAIL dir%0d_timing got lat=%0d busy_ok=%0d BUSY@DONE=%b exp lat=6 busy_ok=1 BUSY=0",
                 i, lat, bok, BUSY);
      end
      checks++;
      if (c !== vcnt[i] || o !== vout[i] || z !== vz[i]) begin
        failures++;
        $display("FAIL dir%0d_result got COUNT=%0d OUT=%h ZERO=%b exp COUNT=%0d OUT=%h ZERO=%b",
                 i, c, o, z, vcnt[i], vout[i], vz[i]);
      end
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (DONE !== 1'b0 || OUT !== vout[i] || COUNT !== vcnt[i]) begin
        failures++;
        $display("FAIL dir%0d_hold got DONE=%b OUT=%h COUNT=%0d exp DONE=0 OUT=%h COUNT=%0d",
                 i, DONE, OUT, COUNT, vout[i], vcnt[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, o, eo; logic [5:0] c, ec; logic z, ez, t; int lat; bit bok;
    for (int i = 0; i < 48; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: a = a >> $urandom_range(0, 31);
        1: a = a << $urandom_range(0, 31);
        2: a = (a >> $urandom_range(0, 31)) << $urandom_range(0, 31);
        default: a = 32'd1 << $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 15) == 0) a = '0;
      t = 1'($urandom_range(0, 1));
      model(a, t, eo, ec, ez);
      do_op(a, t, o, c, z, lat, bok);
      checks++;
      if (lat != 6 || o !== eo || c !== ec || z !== ez) begin
        failures++;
        $display("FAIL rand%0d IN=%h TR=%b got OUT=%h COUNT=%0d ZERO=%b lat=%0d exp OUT=%h COUNT=%0d ZERO=%b lat=6",
                 i, a, t, o, c, z, lat, eo, ec, ez);
      end
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, o, eo; logic [5:0] c, ec; logic z, ez, t; int lat; bit bok;
    for (int i = 0; i < 8; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      t = 1'($urandom_range(0, 1));
      model(a, t, eo, ec, ez);
      do_op(a, t, o, c, z, lat, bok);
      checks++;
      if (lat != 6 || !bok || o !== eo || c !== ec || z !== ez) begin
        failures++;
        $display("FAIL b2b%0d IN=%h got OUT=%h COUNT=%0d lat=%0d busy_ok=%0d exp OUT=%h COUNT=%0d lat=6",
                 i, a, o, c, lat, bok, eo, ec);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    @(negedge CLK);
    IN = 32'h0000_F000; TRAILING = 1'b0; START = 1'b1;
    @(posedge CLK); #1;                     // edge k
    START = 1'b0;
    @(negedge CLK);                         // before k+1
    @(negedge CLK);                         // before k+2
    IN = 32'hFFFF_FFFF; START = 1'b1;
    @(posedge CLK); #1;                     // edge k+2
    START = 1'b0;
    repeat (4) @(negedge CLK);              // before k+6 (FINISH cycle)
    START = 1'b1;
    @(posedge CLK); #1;                     // edge k+6
    START = 1'b0;
    checks++;
    if (DONE !== 1'b1 || COUNT !== 6'd16 || OUT !== 32'hF000_0000 || ZERO !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore got DONE=%b COUNT=%0d OUT=%h exp DONE=1 COUNT=16 OUT=f0000000",
               DONE, COUNT, OUT);
    end
    n = 0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (BUSY !== 1'b0 || DONE !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL busy_not_queued got %0d active cycles exp 0", n);
    end
    IN = '0;
  endtask

  task automatic test_rst_mid();
    logic [31:0] o; logic [5:0] c; logic z; int lat, n; bit bok;
    @(negedge CLK);
    IN = 32'h0000_0003; TRAILING = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({OUT, COUNT, ZERO, BUSY, DONE} !== '0) begin
      failures++;
      $display("FAIL rst_mid got OUT=%h COUNT=%0d BUSY=%b DONE=%b exp 0", OUT, COUNT, BUSY, DONE);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (DONE !== 1'b0 || BUSY !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL rst_mid_discard got %0d DONE/BUSY cycles exp 0", n);
    end
    do_op(32'h0000_0003, 1'b0, o, c, z, lat, bok);
    checks++;
    if (lat != 6 || c !== 6'd30 || o !== 32'hC000_0000 || z !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_rerun got COUNT=%0d OUT=%h lat=%0d exp COUNT=30 OUT=c0000000 lat=6",
               c, o, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_rst_mid();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
